// File: rtl/ddr2_write_burst8.sv
// DDR2 write burst launcher: stages eight 16-bit words and drives one BL8 burst (preamble, 8 beats, postamble).
// Optional byte-mask storage is built when DDR2_WB_DM_EN is defined; otherwise dm_out is tied low.
module ddr2_write_burst8 #(
    parameter int PRE_CYC  = 1,
    parameter int POST_CYC = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [2:0]  load_idx,
    input  logic [15:0] load_data,
    input  logic [1:0]  load_mask,
    input  logic        fire,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        fire_err,
    output logic [15:0] dq_out,
    output logic [1:0]  dm_out,
    output logic        dq_oe,
    output logic        dqs_out,
    output logic        dqs_oe
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_DRIVE,
        ST_POST
    } state_e;

    localparam logic [1:0] PRE_LAST  = 2'(PRE_CYC - 1);
    localparam logic [1:0] POST_LAST = 2'(POST_CYC - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [2:0]  beat_q, beat_d;
    logic [7:0]  bitmap_q, bitmap_d;
    logic [15:0] w_q [8];

    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fire_err_q, fire_err_d;
    logic [15:0] dq_out_q, dq_out_d;
    logic        dq_oe_q, dq_oe_d;
    logic        dqs_out_q, dqs_out_d;
    logic        dqs_oe_q, dqs_oe_d;

    logic        accept;
    logic        load_en;

    // A fire that wins also blocks any load in the same cycle, so the burst sees the prior slot contents.
    assign accept  = fire && ready_q;
    assign load_en = load && (state_q == ST_IDLE) && !accept;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        bitmap_d   = bitmap_q;

        if (load_en) begin
            bitmap_d[load_idx] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_PRE;
                    cnt_d   = 2'd0;
                end
            end
            ST_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = 2'd0;
                    beat_d  = 3'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_DRIVE: begin
                if (beat_q == 3'd7) begin
                    state_d = ST_POST;
                    cnt_d   = 2'd0;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            ST_POST: begin
                if (cnt_q == POST_LAST) begin
                    state_d  = ST_IDLE;
                    bitmap_d = 8'h00;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pin values trail the state register by one cycle, which yields the fire-to-preamble latency.
        ready_d    = (bitmap_d == 8'hFF) && (state_d == ST_IDLE);
        busy_d     = (state_q != ST_IDLE);
        fire_err_d = fire && !ready_q;
        done_d     = (state_q == ST_POST) && (cnt_q == POST_LAST);
        dqs_oe_d   = (state_q != ST_IDLE);
        dq_oe_d    = (state_q == ST_DRIVE);
        dqs_out_d  = (state_q == ST_DRIVE) && !beat_q[0];
        dq_out_d   = (state_q == ST_DRIVE) ? w_q[beat_q] : 16'h0000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            beat_q     <= 3'd0;
            bitmap_q   <= 8'h00;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fire_err_q <= 1'b0;
            dq_out_q   <= 16'h0000;
            dq_oe_q    <= 1'b0;
            dqs_out_q  <= 1'b0;
            dqs_oe_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            bitmap_q   <= bitmap_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fire_err_q <= fire_err_d;
            dq_out_q   <= dq_out_d;
            dq_oe_q    <= dq_oe_d;
            dqs_out_q  <= dqs_out_d;
            dqs_oe_q   <= dqs_oe_d;
        end
    end

    // NOTE: slot storage is reset so a burst can never launch stale data after a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                w_q[i] <= 16'h0000;
            end
        end else if (load_en) begin
            w_q[load_idx] <= load_data;
        end
    end

`ifdef DDR2_WB_DM_EN
    logic [1:0] m_q [8];
    logic [1:0] dm_out_q;
    logic [1:0] dm_out_d;

    assign dm_out_d = (state_q == ST_DRIVE) ? m_q[beat_q] : 2'b00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                m_q[i] <= 2'b00;
            end
            dm_out_q <= 2'b00;
        end else begin
            if (load_en) begin
                m_q[load_idx] <= load_mask;
            end
            dm_out_q <= dm_out_d;
        end
    end

    assign dm_out = dm_out_q;
`else
    logic unused_load_mask;

    assign unused_load_mask = ^load_mask;
    assign dm_out           = 2'b00;
`endif

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fire_err = fire_err_q;
    assign dq_out   = dq_out_q;
    assign dq_oe    = dq_oe_q;
    assign dqs_out  = dqs_out_q;
    assign dqs_oe   = dqs_oe_q;

endmodule

// File: tb/tb_ddr2_write_burst8.sv
// Self-checking bench for ddr2_write_burst8: directed scenarios plus random load/fire traffic,
// all compared against a cycle-list reference model of the burst.
module tb_ddr2_write_burst8;

    localparam int PRE_CYC  = 1;
    localparam int POST_CYC = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [2:0]  load_idx = 3'd0;
    logic [15:0] load_data = 16'h0000;
    logic [1:0]  load_mask = 2'b00;
    logic        fire = 1'b0;
    logic        ready, busy, done, fire_err, dq_oe, dqs_out, dqs_oe;
    logic [15:0] dq_out;
    logic [1:0]  dm_out;

    ddr2_write_burst8 #(
        .PRE_CYC (PRE_CYC),
        .POST_CYC(POST_CYC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_idx (load_idx),
        .load_data(load_data),
        .load_mask(load_mask),
        .fire     (fire),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .fire_err (fire_err),
        .dq_out   (dq_out),
        .dm_out   (dm_out),
        .dq_oe    (dq_oe),
        .dqs_out  (dqs_out),
        .dqs_oe   (dqs_oe)
    );

    always #5 clk = ~clk;

    // One expected pin snapshot per clock.
    typedef struct packed {
        logic        busy;
        logic        dqs_oe;
        logic        dqs_out;
        logic        dq_oe;
        logic        done;
        logic [15:0] dq;
        logic [1:0]  dm;
    } out_t;

    out_t        exp_q[$];
    out_t        exp_now;
    logic [15:0] mw [8];
    logic [1:0]  mm [8];
    logic [7:0]  mloaded;
    logic        exp_ready;
    logic        exp_err;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_now   = '0;
        mloaded   = 8'h00;
        exp_ready = 1'b0;
        exp_err   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mw[i] = 16'h0000;
            mm[i] = 2'b00;
        end
    endtask

    // Applies one clock edge worth of inputs to the model.
    task automatic model_step(input logic l, input logic [2:0] idx, input logic [15:0] d,
                              input logic [1:0] m, input logic f);
        logic accept;
        logic was_busy;
        out_t e;
        accept   = f && exp_ready;
        was_busy = (exp_q.size() != 0);
        exp_err  = f && !exp_ready;
        if (l && !was_busy && !accept) begin
            mw[idx]      = d;
            mm[idx]      = m;
            mloaded[idx] = 1'b1;
        end
        if (accept) begin
            exp_q.push_back('0);
            for (int i = 0; i < PRE_CYC; i++) begin
                e = '0; e.busy = 1'b1; e.dqs_oe = 1'b1;
                exp_q.push_back(e);
            end
            for (int b = 0; b < 8; b++) begin
                e = '0; e.busy = 1'b1; e.dqs_oe = 1'b1; e.dq_oe = 1'b1;
                e.dqs_out = (b % 2 == 0);
                e.dq = mw[b];
`ifdef DDR2_WB_DM_EN
                e.dm = mm[b];
`endif
                exp_q.push_back(e);
            end
            for (int i = 0; i < POST_CYC; i++) begin
                e = '0; e.busy = 1'b1; e.dqs_oe = 1'b1;
                e.done = (i == POST_CYC - 1);
                exp_q.push_back(e);
            end
        end
        exp_now = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        if (was_busy && exp_q.size() == 0) mloaded = 8'h00;
        exp_ready = (mloaded == 8'hFF) && (exp_q.size() == 0);
    endtask

    task automatic check_all();
        check("ready",    32'(ready),    32'(exp_ready));
        check("fire_err", 32'(fire_err), 32'(exp_err));
        check("busy",     32'(busy),     32'(exp_now.busy));
        check("done",     32'(done),     32'(exp_now.done));
        check("dq_out",   32'(dq_out),   32'(exp_now.dq));
        check("dm_out",   32'(dm_out),   32'(exp_now.dm));
        check("dq_oe",    32'(dq_oe),    32'(exp_now.dq_oe));
        check("dqs_out",  32'(dqs_out),  32'(exp_now.dqs_out));
        check("dqs_oe",   32'(dqs_oe),   32'(exp_now.dqs_oe));
    endtask

    // Inputs set before the call are sampled at the next edge; outputs are checked 1 ns later.
    task automatic tick();
        logic        l, f;
        logic [2:0]  idx;
        logic [15:0] d;
        logic [1:0]  m;
        l = load; f = fire; idx = load_idx; d = load_data; m = load_mask;
        @(posedge clk);
        #1;
        if (reset) model_reset();
        else model_step(l, idx, d, m, f);
        check_all();
        load = 1'b0;
        fire = 1'b0;
    endtask

    task automatic load_slot(input int idx, input logic [15:0] d, input logic [1:0] m);
        load = 1'b1; load_idx = 3'(idx); load_data = d; load_mask = m;
        tick();
    endtask

    task automatic load_all_random();
        for (int i = 0; i < 8; i++) load_slot(i, 16'($urandom), 2'($urandom));
    endtask

    task automatic fire_and_run(input int n);
        fire = 1'b1;
        tick();
        repeat (n) tick();
    endtask

    localparam int BURST_LEN = PRE_CYC + 8 + POST_CYC + 2;

    initial begin
        model_reset();
        tick();
        tick();
        #2 reset = 1'b0;

        // Basic burst with incrementing data.
        for (int i = 0; i < 8; i++) load_slot(i, 16'h1000 + 16'(i), 2'b00);
        check("ready_before_fire", 32'(ready), 32'd1);
        fire_and_run(BURST_LEN);

        // Incomplete staging rejects fire, then the full set fires.
        for (int i = 0; i < 7; i++) load_slot(i, 16'($urandom), 2'b00);
        fire_and_run(2);
        load_slot(7, 16'h7777, 2'b01);
        fire_and_run(BURST_LEN);

        // Load and fire attempt during beat 3 are both ignored.
        load_all_random();
        fire_and_run(PRE_CYC + 4);
        load = 1'b1; load_idx = 3'd2; load_data = 16'hDEAD; fire = 1'b1;
        tick();
        repeat (BURST_LEN) tick();
        for (int i = 0; i < 7; i++) load_slot(i, 16'($urandom), 2'b00);
        check("ready_partial_reload", 32'(ready), 32'd0);

        // Same-cycle load with accepted fire keeps the prior slot value.
        load_slot(7, 16'h0007, 2'b00);
        load = 1'b1; load_idx = 3'd5; load_data = 16'hBEEF;
        fire_and_run(BURST_LEN);

        // Asynchronous reset at beat 4.
        load_all_random();
        fire_and_run(PRE_CYC + 5);
        #2 reset = 1'b1;
        #1;
        check("rst_dq_oe",  32'(dq_oe),  32'd0);
        check("rst_dqs_oe", 32'(dqs_oe), 32'd0);
        check("rst_dq_out", 32'(dq_out), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        tick();
        #2 reset = 1'b0;
        repeat (BURST_LEN) tick();
        check("ready_after_rst", 32'(ready), 32'd0);

        // Mask on slot 6 only.
        for (int i = 0; i < 8; i++) load_slot(i, 16'h2000 + 16'(i), (i == 6) ? 2'b10 : 2'b00);
        fire_and_run(BURST_LEN);

        // Random traffic.
        for (int c = 0; c < 800; c++) begin
            load      = ($urandom_range(0, 1) == 1);
            load_idx  = 3'($urandom);
            load_data = 16'($urandom);
            load_mask = 2'($urandom);
            fire      = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
